// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq : reset sequencer behind the board clock input path.
//
// Waits for the clock source to report lock, filters the lock indication,
// holds every downstream domain in reset for a fixed interval, then releases
// up to eight reset domains one after another with a fixed gap and raises
// o_ready. Lock loss re-runs the whole sequence. Optionally a software reset
// request/acknowledge handshake re-sequences from HOLD.
//
// Optional feature macro: RST_SEQ_SW_RST_EN
//   defined   : SW_RESET state and the req/ack handshake are built.
//   undefined : i_sw_rst_req is ignored, o_sw_rst_ack stays 0.
//
// Parameters:
//   NUM_STAGES  number of staged reset outputs (1..8)
//   LOCK_FILTER consecutive synchronized-lock cycles needed before HOLD (>=1)
//   HOLD_CYCLES cycles spent in HOLD before the first release (>=1)
//   STAGE_GAP   cycles between consecutive stage releases (>=1)
//
// Ports:
//   i_clk          system clock (buffered global clock)
//   i_rst_n        asynchronous active-low reset
//   i_locked       clock-source lock, asynchronous, 2-flop synchronized here
//   i_sw_rst_req   synchronous software reset request (level, 4-phase)
//   o_sw_rst_ack   software reset acknowledge (registered)
//   o_stage_rst_n  active-low reset per domain, bit k releases before bit k+1
//   o_ready        high only in RUN (registered)
// -----------------------------------------------------------------------------
module rst_seq #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_locked,
    input  logic                  i_sw_rst_req,
    output logic                  o_sw_rst_ack,
    output logic [NUM_STAGES-1:0] o_stage_rst_n,
    output logic                  o_ready
);

    localparam int MAX_AB = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
    localparam int CNT_W = $clog2(MAX_CNT + 1);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RELEASE   = 3'd2,
`ifdef RST_SEQ_SW_RST_EN
        ST_RUN       = 3'd3,
        ST_SW_RESET  = 3'd4
`else
        ST_RUN       = 3'd3
`endif
    } state_t;

    logic                  r_sync_q1;
    logic                  r_locked_s;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_ready;
    logic                  r_sw_rst_ack;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic                  w_ready_nxt;
    logic                  w_ack_nxt;

`ifndef RST_SEQ_SW_RST_EN
    // Request input is intentionally unused when the handshake is not built.
    logic w_unused_sw_req;
    assign w_unused_sw_req = i_sw_rst_req;
`endif

    // Two-flop synchronizer bringing the asynchronous lock into i_clk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_q1  <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync_q1  <= i_locked;
            r_locked_s <= r_sync_q1;
        end
    end

    // State, shared counter, stage index and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_WAIT_LOCK;
            r_cnt         <= {CNT_W{1'b0}};
            r_idx         <= {IDX_W{1'b0}};
            r_stage_rst_n <= {NUM_STAGES{1'b0}};
            r_ready       <= 1'b0;
            r_sw_rst_ack  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_stage_rst_n <= w_stage_nxt;
            r_ready       <= w_ready_nxt;
            r_sw_rst_ack  <= w_ack_nxt;
        end
    end

    // Next-state and next-output logic; lock loss overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_stage_nxt = r_stage_rst_n;
        w_ready_nxt = r_ready;
        w_ack_nxt   = r_sw_rst_ack;

        if ((r_state != ST_WAIT_LOCK) && !r_locked_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_idx_nxt   = {IDX_W{1'b0}};
            w_stage_nxt = {NUM_STAGES{1'b0}};
            w_ready_nxt = 1'b0;
            w_ack_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_stage_nxt = {NUM_STAGES{1'b0}};
                    w_ready_nxt = 1'b0;
                    w_ack_nxt   = 1'b0;
                    if (r_locked_s) begin
                        if (r_cnt == LOCK_LAST) begin
                            w_state_nxt = ST_HOLD;
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                    end
                end

                ST_HOLD: begin
                    w_stage_nxt = {NUM_STAGES{1'b0}};
                    w_ready_nxt = 1'b0;
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_idx_nxt   = {IDX_W{1'b0}};
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end

                // r_cnt==0 is the edge that raises bit r_idx. After the last
                // bit the counter is left non-zero so the next edge enters RUN.
                ST_RELEASE: begin
                    if ((r_idx == IDX_LAST) && (r_cnt != {CNT_W{1'b0}})) begin
                        w_state_nxt = ST_RUN;
                        w_ready_nxt = 1'b1;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else if (r_cnt == {CNT_W{1'b0}}) begin
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (IDX_W'(k) == r_idx) begin
                                w_stage_nxt[k] = 1'b1;
                            end else begin
                                w_stage_nxt[k] = r_stage_rst_n[k];
                            end
                        end
                        if ((r_idx != IDX_LAST) && (GAP_LAST == {CNT_W{1'b0}})) begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end else begin
                            w_cnt_nxt = CNT_W'(1);
                        end
                    end else if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    w_ready_nxt = 1'b1;
`ifdef RST_SEQ_SW_RST_EN
                    if (i_sw_rst_req) begin
                        w_state_nxt = ST_SW_RESET;
                        w_stage_nxt = {NUM_STAGES{1'b0}};
                        w_ready_nxt = 1'b0;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_ack_nxt = 1'b0;
                    end
`else
                    w_ack_nxt = 1'b0;
`endif
                end

`ifdef RST_SEQ_SW_RST_EN
                // Lock is still valid here, so the retry skips WAIT_LOCK.
                ST_SW_RESET: begin
                    w_stage_nxt = {NUM_STAGES{1'b0}};
                    w_ready_nxt = 1'b0;
                    if (!i_sw_rst_req) begin
                        w_ack_nxt   = 1'b0;
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_ack_nxt = 1'b1;
                    end
                end
`endif

                default: begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_stage_nxt = {NUM_STAGES{1'b0}};
                    w_ready_nxt = 1'b0;
                    w_ack_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign o_stage_rst_n = r_stage_rst_n;
    assign o_ready       = r_ready;
    assign o_sw_rst_ack  = r_sw_rst_ack;

endmodule
